// File: rtl/glb_rd_stream.sv
// glb_rd_stream
// Read-side streaming controller sitting in front of a global-buffer RAM bank
// that has a 1-cycle read latency. It accepts a burst command, issues reads to
// the bank, captures every returned word in a 3-entry FIFO and presents the
// words as a valid/ready stream with a last marker.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         burst command handshake (ready only in IDLE)
//   cmd_addr, cmd_len           first word address, word count (0 = no-op)
//   ram_read_en, ram_addr_r     bank read strobe and address
//   ram_data_out                bank read data, valid the cycle after read_en
//   dout_valid/dout_ready       output stream handshake
//   dout_data, dout_last        FIFO head word and its end-of-burst tag
//   busy                        controller not in IDLE
//   done                        one-cycle pulse after the burst completes
module glb_rd_stream #(
  parameter int SRAM_WIDTH = 256,
  parameter int SRAM_WORD  = 64,
  parameter int ADDR_WIDTH = $clog2(SRAM_WORD),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_read_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [SRAM_WIDTH-1:0] ram_data_out,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [SRAM_WIDTH-1:0] dout_data,
  output logic                  dout_last,
  output logic                  busy,
  output logic                  done
);

  localparam int                    FIFO_DEPTH = 3;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = ADDR_WIDTH'(SRAM_WORD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]  rem_reg, rem_next;
  logic                  pending_reg;
  logic                  pending_last_reg;
  logic                  done_reg, done_next;
  logic                  issue;
  logic                  issue_last;

  logic [SRAM_WIDTH-1:0] fifo_data_reg [FIFO_DEPTH];
  logic                  fifo_last_reg [FIFO_DEPTH];
  logic [1:0]            wr_ptr_reg;
  logic [1:0]            rd_ptr_reg;
  logic [1:0]            fifo_cnt_reg;
  logic                  push;
  logic                  pop;
  logic [2:0]            occupancy;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already in the FIFO plus the one still in flight from the bank.
  // Issuing only while this is below the depth guarantees every returned
  // word has a slot, so backpressure never loses RAM data.
  assign occupancy = {1'b0, fifo_cnt_reg} + {2'b00, pending_reg};

  assign push = pending_reg;
  assign pop  = dout_valid & dout_ready;

  // ---------------------------------------------------------------------------
  // FSM next-state logic. Issue decisions depend on registered state only,
  // so there is no combinational path from dout_ready to the RAM strobe.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rem_next   = rem_reg;
    done_next  = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_next = cmd_addr;
          rem_next  = cmd_len;
          if (cmd_len != '0) begin
            state_next = ST_ISSUE;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        if (occupancy < 3'd3) begin
          issue     = 1'b1;
          addr_next = (addr_reg == ADDR_MAX) ? '0 : addr_reg + ADDR_WIDTH'(1);
          rem_next  = rem_reg - LEN_WIDTH'(1);
          if (rem_reg == LEN_WIDTH'(1)) begin
            issue_last = 1'b1;
            state_next = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (pop && dout_last) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      addr_reg         <= '0;
      rem_reg          <= '0;
      pending_reg      <= 1'b0;
      pending_last_reg <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      addr_reg         <= addr_next;
      rem_reg          <= rem_next;
      pending_reg      <= issue;
      pending_last_reg <= issue_last;
      done_reg         <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // 3-entry output FIFO. Storage carries no reset; the head is gated by
  // dout_valid so the visible data is zero whenever the FIFO is empty.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_reg[wr_ptr_reg] <= ram_data_out;
      fifo_last_reg[wr_ptr_reg] <= pending_last_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= 2'd0;
      rd_ptr_reg   <= 2'd0;
      fifo_cnt_reg <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // A push into a full FIFO would mean the issue throttle is broken.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (fifo_cnt_reg == 2'd3)));

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready   = (state_reg == ST_IDLE);
  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;
  assign ram_read_en = issue;
  assign ram_addr_r  = addr_reg;
  assign dout_valid  = (fifo_cnt_reg != 2'd0);
  assign dout_data   = dout_valid ? fifo_data_reg[rd_ptr_reg] : '0;
  assign dout_last   = dout_valid ? fifo_last_reg[rd_ptr_reg] : 1'b0;

endmodule

// File: tb/tb_glb_rd_stream.sv
// tb_glb_rd_stream
// Self-checking bench for glb_rd_stream. A bank model answers reads one cycle
// later. The reference model turns each accepted command into the list of
// addresses that must be read and the words (with last tag) that must come
// out, and derives busy/done timing from when the last word is transferred.
// A negedge monitor compares the DUT against that model every cycle; the
// directed sections add literal cycle/address expectations.
module tb_glb_rd_stream;

  localparam int SRAM_WIDTH = 256;
  localparam int SRAM_WORD  = 64;
  localparam int ADDR_WIDTH = 6;
  localparam int LEN_WIDTH  = 7;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr = '0;
  logic [LEN_WIDTH-1:0]  cmd_len = '0;
  logic                  ram_read_en;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [SRAM_WIDTH-1:0] ram_q = '0;
  logic                  dout_valid;
  logic                  dout_ready = 1'b1;
  logic [SRAM_WIDTH-1:0] dout_data;
  logic                  dout_last;
  logic                  busy;
  logic                  done;

  glb_rd_stream #(
    .SRAM_WIDTH(SRAM_WIDTH),
    .SRAM_WORD (SRAM_WORD),
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .ram_read_en (ram_read_en),
    .ram_addr_r  (ram_addr_r),
    .ram_data_out(ram_q),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_data   (dout_data),
    .dout_last   (dout_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: registered read, data valid the cycle after read_en.
  logic [SRAM_WIDTH-1:0] mem [SRAM_WORD];
  always @(posedge clk) if (ram_read_en) ram_q <= mem[ram_addr_r];

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [SRAM_WIDTH-1:0] data;
    logic                  last;
  } word_t;

  int    addr_q[$];
  word_t word_q[$];
  bit    busy_m = 1'b0;
  int    done_due = -10;
  int    issued_cnt = 0;
  int    popped_cnt = 0;
  int    done_count = 0;

  // Per-burst observations, measured relative to the acceptance cycle.
  int                    acc_cyc = 0;
  int                    first_rd_rel = -1;
  int                    last_rd_rel = -1;
  int                    last_rd_addr = -1;
  int                    first_valid_rel = -1;
  int                    valid_cycles = 0;
  int                    done_rel = -1;
  logic [SRAM_WIDTH-1:0] last_word = '0;

  bit                    prev_stall = 1'b0;
  logic [SRAM_WIDTH-1:0] prev_data = '0;
  logic                  prev_last = 1'b0;

  bit rand_mode = 1'b0;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [SRAM_WIDTH-1:0] act,
                     input logic [SRAM_WIDTH-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_ok(input string name, input bit ok, input int val);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: observed %0d (cycle %0d)", name, val, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : mon
    int    rel;
    bit    idle_now;
    int    a;
    word_t w;
    if (!rst_n) begin
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_read_en", ram_read_en, 0);
      chk("rst_addr_r", ram_addr_r, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_dout_data", dout_data, 0);
      chk("rst_dout_last", dout_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      addr_q.delete();
      word_q.delete();
      busy_m     = 1'b0;
      done_due   = -10;
      issued_cnt = 0;
      popped_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      rel      = cyc - acc_cyc;
      idle_now = !busy_m;

      chk("done", done, (cyc == done_due));
      if (done) begin
        done_count++;
        done_rel = rel;
        $display("done at cycle %0d (rel %0d)", cyc, rel);
      end
      chk("busy", busy, busy_m);
      chk("cmd_ready", cmd_ready, idle_now);

      if (ram_read_en) begin
        issued_cnt++;
        if (addr_q.size() == 0) chk_ok("spurious_read", 1'b0, int'(ram_addr_r));
        else chk("read_addr", ram_addr_r, addr_q.pop_front());
        if (first_rd_rel < 0) first_rd_rel = rel;
        last_rd_rel  = rel;
        last_rd_addr = int'(ram_addr_r);
      end
      chk_ok("occupancy_le_3", (issued_cnt - popped_cnt) <= 3, issued_cnt - popped_cnt);

      if (prev_stall) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_data", dout_data, prev_data);
        chk("hold_last", dout_last, prev_last);
      end

      if (dout_valid) begin
        valid_cycles++;
        if (first_valid_rel < 0) first_valid_rel = rel;
        if (word_q.size() == 0) chk_ok("spurious_valid", 1'b0, cyc);
      end

      if (dout_valid && dout_ready && word_q.size() != 0) begin
        w = word_q.pop_front();
        chk("word_data", dout_data, w.data);
        chk("word_last", dout_last, w.last);
        popped_cnt++;
        last_word = dout_data;
        $display("word %0d cycle %0d last=%0d data=%h", popped_cnt, cyc, dout_last, dout_data);
        if (w.last) begin
          done_due = cyc + 1;
          busy_m   = 1'b0;
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_data  = dout_data;
      prev_last  = dout_last;

      if (cmd_valid && idle_now) begin
        acc_cyc         = cyc;
        first_rd_rel    = -1;
        last_rd_rel     = -1;
        last_rd_addr    = -1;
        first_valid_rel = -1;
        valid_cycles    = 0;
        done_rel        = -1;
        for (int i = 0; i < int'(cmd_len); i++) begin
          a = (int'(cmd_addr) + i) % SRAM_WORD;
          addr_q.push_back(a);
          w.data = mem[a];
          w.last = (i == int'(cmd_len) - 1);
          word_q.push_back(w);
        end
        if (cmd_len == 0) done_due = cyc + 1;
        else busy_m = 1'b1;
        $display("cmd addr=%0d len=%0d accepted cycle %0d", cmd_addr, cmd_len, cyc);
      end
    end
  end

  // Random downstream backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) dout_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Holds cmd_valid until a cycle with cmd_ready high; returns #1 after the
  // accepting edge (i.e. in cycle 1 of the burst).
  task automatic send_cmd(input int a, input int l);
    bit ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = ADDR_WIDTH'(a);
    cmd_len   = LEN_WIDTH'(l);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk_ok("cmd_accepted", ok, a);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy_m || word_q.size() != 0 || cyc <= done_due) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_ok("idle_within_budget", n < budget, n);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int dc0;
    for (int i = 0; i < SRAM_WORD; i++)
      for (int j = 0; j < SRAM_WIDTH / 32; j++)
        mem[i][j*32 +: 32] = $urandom;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst: addr 4, 8 words, no stall.
    dc0 = done_count;
    send_cmd(4, 8);
    wait_idle(200);
    chk("basic_first_read_cycle", first_rd_rel, 1);
    chk("basic_last_read_cycle", last_rd_rel, 8);
    chk("basic_last_read_addr", last_rd_addr, 11);
    chk("basic_first_valid_cycle", first_valid_rel, 3);
    chk("basic_valid_cycles", valid_cycles, 8);
    chk("basic_done_cycle", done_rel, 11);
    chk("basic_last_word", last_word, mem[11]);
    chk("basic_done_once", done_count - dc0, 1);

    // Address wrap: 62, 63, 0, 1.
    send_cmd(62, 4);
    wait_idle(200);
    chk("wrap_last_read_addr", last_rd_addr, 1);
    chk("wrap_last_word", last_word, mem[1]);
    chk("wrap_done_cycle", done_rel, 7);

    // Backpressure: dout_ready low in cycles 2..12.
    dc0 = done_count;
    send_cmd(20, 10);
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("bp_last_read_cycle", last_rd_rel, 3);
    chk("bp_buffered_words", issued_cnt - popped_cnt, 3);
    chk("bp_valid_while_stalled", dout_valid, 1);
    dout_ready = 1'b1;
    wait_idle(200);
    chk("bp_done_once", done_count - dc0, 1);
    chk("bp_last_word", last_word, mem[29]);

    // Zero length.
    dc0 = done_count;
    send_cmd(5, 0);
    wait_idle(50);
    chk("zero_done_cycle", done_rel, 1);
    chk_ok("zero_no_read", first_rd_rel < 0, first_rd_rel);
    chk("zero_no_valid", valid_cycles, 0);
    chk("zero_done_once", done_count - dc0, 1);

    // Reset in cycle 5 of a 16-word burst, then a fresh 2-word burst.
    send_cmd(30, 16);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dc0 = done_count;
    send_cmd(0, 2);
    wait_idle(100);
    chk("post_rst_done_cycle", done_rel, 5);
    chk("post_rst_last_word", last_word, mem[1]);
    chk("post_rst_done_once", done_count - dc0, 1);

    // Random backpressure: full-depth burst, then back-to-back random bursts.
    rand_mode = 1'b1;
    dc0 = done_count;
    send_cmd($urandom_range(0, SRAM_WORD - 1), 64);
    for (int k = 0; k < 12; k++)
      send_cmd($urandom_range(0, SRAM_WORD - 1), $urandom_range(0, 20));
    wait_idle(4000);
    rand_mode = 1'b0;
    dout_ready = 1'b1;
    chk("rand_done_count", done_count - dc0, 13);
    chk("rand_all_popped", issued_cnt - popped_cnt, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
